// File: rtl/md_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : md_link_pkg                                                |
// | Purpose  : Shared types and defaults for the MD_Wrapper host link:    |
// |            controller state encoding, record widths, step width and   |
// |            the width of the shared down-counter.                      |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package md_link_pkg;

    localparam int c_DIN_W  = 210;   // particle record into the wrapper
    localparam int c_DOUT_W = 192;   // result record out of the wrapper
    localparam int c_STEP_W = 32;    // timestep counter
    localparam int c_CNT_W  = 32;    // gap / settle / timeout counter

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LD_WAIT = 4'd1,
        ST_LD_WR   = 4'd2,
        ST_LD_GAP  = 4'd3,
        ST_SETTLE  = 4'd4,
        ST_RD_REQ  = 4'd5,
        ST_RD_REL  = 4'd6,
        ST_OUT     = 4'd7,
        ST_FIN     = 4'd8
    } link_state_e;

endpackage
`default_nettype wire

// File: rtl/md_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : md_down_counter                                            |
// | Purpose  : Loadable down-counter with zero flag. Saturates at zero so |
// |            the owner may keep decrement asserted while it waits on    |
// |            the flag.                                                  |
// | Ports    : clk, rst (async, active-high), i_load, i_load_val, i_dec,  |
// |            o_zero                                                     |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module md_down_counter
    import md_link_pkg::*;
#(
    parameter int WIDTH = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/md_host_link.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : md_host_link                                               |
// | Purpose  : Host-side driver for the MD_Wrapper particle port. Loads   |
// |            NUM_PARTICLES records from a valid/ready source through    |
// |            elem_write/d_in, waits SETTLE_CYCLES, then drains the      |
// |            results over the read_ctrl/elem_read 4-phase handshake     |
// |            onto a valid/ready result stream and advances step.        |
// | Ports    : ap_clk, reset (async, active-high), start,                 |
// |            src_valid/src_data/src_ready (host record in),             |
// |            elem_write/d_in (wrapper write port),                      |
// |            read_ctrl/elem_read/d_out (wrapper read port),             |
// |            res_valid/res_data/res_ready (host result out),            |
// |            step, busy, done                                           |
// | Options  : MD_HOST_LINK_READ_TIMEOUT_EN adds parameter RD_TIMEOUT and |
// |            output rd_timeout; a stalled read handshake then aborts    |
// |            the run back to IDLE.                                      |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module md_host_link
    import md_link_pkg::*;
#(
    parameter int NUM_PARTICLES = 300,
    parameter int IDX_W         = 9,
    parameter int DIN_W         = c_DIN_W,
    parameter int DOUT_W        = c_DOUT_W,
    parameter int GAP_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 10000
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
    ,
    parameter int RD_TIMEOUT    = 4096
`endif
) (
    input  logic                ap_clk,
    input  logic                reset,
    input  logic                start,
    input  logic                src_valid,
    input  logic [DIN_W-1:0]    src_data,
    output logic                src_ready,
    output logic                elem_write,
    output logic [DIN_W-1:0]    d_in,
    output logic                read_ctrl,
    input  logic                elem_read,
    input  logic [DOUT_W-1:0]   d_out,
    output logic                res_valid,
    output logic [DOUT_W-1:0]   res_data,
    input  logic                res_ready,
    output logic [c_STEP_W-1:0] step,
    output logic                busy,
    output logic                done
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
    ,
    output logic                rd_timeout
`endif
);

    localparam logic [IDX_W-1:0]   c_LAST_IDX    = IDX_W'(NUM_PARTICLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD    = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYCLES - 1);
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
    localparam logic [c_CNT_W-1:0] c_TO_LOAD     = c_CNT_W'(RD_TIMEOUT - 1);
`endif

    link_state_e        r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               w_last;
    logic               w_cnt_load;
    logic               w_cnt_dec;
    logic [c_CNT_W-1:0] w_cnt_val;
    logic               w_cnt_zero;

    assign w_last    = (r_idx == c_LAST_IDX);
    assign src_ready = (r_state == ST_LD_WAIT);
    assign busy      = (r_state != ST_IDLE);

    // One counter serves the inter-write gap, the settle interval and the
    // read watchdog; those phases never overlap. A phase that ends on the
    // zero flag lasts exactly (load value + 1) cycles.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_cnt_val  = c_GAP_LOAD;
        case (r_state)
            ST_LD_WR: begin
                w_cnt_load = 1'b1;
                w_cnt_val  = w_last ? c_SETTLE_LOAD : c_GAP_LOAD;
            end
            ST_LD_GAP: w_cnt_dec = 1'b1;
            ST_SETTLE: begin
                w_cnt_dec = 1'b1;
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
                w_cnt_load = w_cnt_zero;
                w_cnt_val  = c_TO_LOAD;
`endif
            end
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
            // Each handshake phase gets its own full watchdog window.
            ST_RD_REQ: begin
                w_cnt_dec  = 1'b1;
                w_cnt_load = elem_read;
                w_cnt_val  = c_TO_LOAD;
            end
            ST_RD_REL: w_cnt_dec = 1'b1;
            ST_OUT: begin
                w_cnt_load = res_ready && !w_last;
                w_cnt_val  = c_TO_LOAD;
            end
`endif
            default: ;
        endcase
    end

    md_down_counter #(
        .WIDTH (c_CNT_W)
    ) u_cnt (
        .clk        (ap_clk),
        .rst        (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            d_in       <= '0;
            res_data   <= '0;
            step       <= '0;
            elem_write <= 1'b0;
            read_ctrl  <= 1'b0;
            res_valid  <= 1'b0;
            done       <= 1'b0;
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
            rd_timeout <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes default low.
            elem_write <= 1'b0;
            done       <= 1'b0;
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
            rd_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_state <= ST_LD_WAIT;
                    end
                end
                ST_LD_WAIT: begin
                    if (src_valid) begin
                        d_in       <= src_data;
                        elem_write <= 1'b1;
                        r_state    <= ST_LD_WR;
                    end
                end
                ST_LD_WR: begin
                    if (w_last) begin
                        r_state <= ST_SETTLE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= ST_LD_GAP;
                    end
                end
                ST_LD_GAP: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_LD_WAIT;
                    end
                end
                ST_SETTLE: begin
                    if (w_cnt_zero) begin
                        r_idx     <= '0;
                        read_ctrl <= 1'b1;
                        r_state   <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (elem_read) begin
                        res_data  <= d_out;
                        read_ctrl <= 1'b0;
                        r_state   <= ST_RD_REL;
                    end
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
                    else if (w_cnt_zero) begin
                        read_ctrl  <= 1'b0;
                        rd_timeout <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
`endif
                end
                ST_RD_REL: begin
                    // Wrapper must drop its acknowledge before the next
                    // request can be raised.
                    if (!elem_read) begin
                        res_valid <= 1'b1;
                        r_state   <= ST_OUT;
                    end
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
                    else if (w_cnt_zero) begin
                        rd_timeout <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
`endif
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (w_last) begin
                            done    <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_idx     <= r_idx + IDX_W'(1);
                            read_ctrl <= 1'b1;
                            r_state   <= ST_RD_REQ;
                        end
                    end
                end
                ST_FIN: begin
                    step    <= step + c_STEP_W'(1);
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_host_link.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_md_host_link                                            |
// | Purpose  : Self-checking bench for md_host_link with a small          |
// |            configuration (4 particles, gap 3, settle 5). Random       |
// |            records, a behavioural MD_Wrapper read-port model and a    |
// |            host sink; expected values come from the transfer rules.   |
// | Options  : MD_HOST_LINK_READ_TIMEOUT_EN also exercises the watchdog.  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_md_host_link;

    localparam int NUM    = 4;
    localparam int IDX_W  = 3;
    localparam int DIN_W  = 210;
    localparam int DOUT_W = 192;
    localparam int GAP    = 3;
    localparam int SETTLE = 5;
    localparam int RDTO   = 8;
    localparam int BUDGET = 2000;

    typedef logic [255:0] chk_t;

    logic              ap_clk = 1'b0;
    logic              reset;
    logic              start;
    logic              src_valid;
    logic [DIN_W-1:0]  src_data;
    logic              src_ready;
    logic              elem_write;
    logic [DIN_W-1:0]  d_in;
    logic              read_ctrl;
    logic              elem_read;
    logic [DOUT_W-1:0] d_out;
    logic              res_valid;
    logic [DOUT_W-1:0] res_data;
    logic              res_ready;
    logic [31:0]       step;
    logic              busy;
    logic              done;
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
    logic              rd_timeout;
`endif

    md_host_link #(
        .NUM_PARTICLES (NUM),
        .IDX_W         (IDX_W),
        .DIN_W         (DIN_W),
        .DOUT_W        (DOUT_W),
        .GAP_CYCLES    (GAP),
        .SETTLE_CYCLES (SETTLE)
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
        ,
        .RD_TIMEOUT    (RDTO)
`endif
    ) dut (
        .ap_clk     (ap_clk),
        .reset      (reset),
        .start      (start),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .elem_write (elem_write),
        .d_in       (d_in),
        .read_ctrl  (read_ctrl),
        .elem_read  (elem_read),
        .d_out      (d_out),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .step       (step),
        .busy       (busy),
        .done       (done)
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
        ,
        .rd_timeout (rd_timeout)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // ---------------- bench state ----------------
    int                cyc = 0;
    logic [DIN_W-1:0]  rec [NUM];
    int                hs_cyc [NUM];
    int                wr_cyc_q [$];
    logic [DIN_W-1:0]  wr_dat_q [$];
    int                rd_rise_q [$];
    int                to_cyc_q [$];
    logic [DOUT_W-1:0] got_q [$];
    int                ew_wide = 0;
    int                rc_viol = 0;
    int                rv_viol = 0;
    int                done_cnt = 0;
    bit                prev_ew = 1'b0;
    bit                prev_rc = 1'b0;
    bit                eager = 1'b0;
    bit                stuck = 1'b0;
    int                exp_step = 0;
    int                rd_base = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input chk_t obs, input chk_t exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- observation of DUT outputs ----------------
    always @(negedge ap_clk) begin
        if (!reset) begin
            if (elem_write) begin
                wr_cyc_q.push_back(cyc);
                wr_dat_q.push_back(d_in);
                if (prev_ew) ew_wide++;
            end
            if (read_ctrl && !prev_rc) begin
                rd_rise_q.push_back(cyc);
                if (elem_read && !eager) rc_viol++;
            end
            if (res_valid && read_ctrl) rv_viol++;
            if (done) done_cnt++;
`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
            if (rd_timeout) to_cyc_q.push_back(cyc);
`endif
        end
        prev_ew = elem_write;
        prev_rc = read_ctrl;
    end

    // ---------------- MD_Wrapper read-port model ----------------
    // Ack i carries 0xA0 + i. Normally acks 3 cycles after the request; in
    // eager mode the ack is already up before the request arrives.
    initial begin
        int nxt;
        nxt = 0;
        elem_read = 1'b0;
        d_out = '0;
        forever begin
            if (eager) begin
                @(posedge ap_clk); #1;
                elem_read = 1'b1;
                d_out = DOUT_W'(32'hA0 + nxt);
                do @(negedge ap_clk); while (!read_ctrl);
            end else begin
                do @(negedge ap_clk); while (!read_ctrl);
                if (stuck) begin
                    do @(negedge ap_clk); while (read_ctrl);
                    continue;
                end
                repeat (3) @(posedge ap_clk);
                #1;
                elem_read = 1'b1;
                d_out = DOUT_W'(32'hA0 + nxt);
            end
            do @(negedge ap_clk); while (read_ctrl);
            @(posedge ap_clk); #1;
            elem_read = 1'b0;
            nxt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        @(posedge ap_clk); #1;
        start = 1'b1;
        @(posedge ap_clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_src(input bit stall, output bit to);
        to = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            int g;
            g = 0;
            if (stall && k == 2) begin
                src_valid = 1'b0;
                repeat (20) @(posedge ap_clk);
                #1;
            end
            src_valid = 1'b1;
            src_data  = rec[k];
            do begin @(negedge ap_clk); g++; end while (!src_ready && g < BUDGET);
            if (!src_ready) begin
                to = 1'b1;
                src_valid = 1'b0;
                return;
            end
            @(posedge ap_clk); #1;
            hs_cyc[k] = cyc;
        end
        src_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd, output bit to);
        int g;
        g = 0;
        got_q.delete();
        res_ready = rnd ? 1'($urandom % 2) : 1'b1;
        while (got_q.size() < NUM && g < BUDGET) begin
            @(negedge ap_clk);
            g++;
            if (res_valid && res_ready) got_q.push_back(res_data);
            @(posedge ap_clk); #1;
            res_ready = rnd ? 1'($urandom % 2) : 1'b1;
        end
        res_ready = 1'b0;
        to = (got_q.size() < NUM);
    endtask

    task automatic new_records();
        logic [223:0] wide;
        for (int k = 0; k < NUM; k++) begin
            wide = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rec[k] = wide[DIN_W-1:0];
        end
    endtask

    task automatic clear_obs();
        wr_cyc_q.delete();
        wr_dat_q.delete();
        rd_rise_q.delete();
        to_cyc_q.delete();
        ew_wide = 0;
        rc_viol = 0;
        rv_viol = 0;
    endtask

    // One full timestep, checked against the transfer rules.
    task automatic run_once(input bit stall, input bit rnd, input bit poke);
        bit src_to, snk_to;
        int done_before, g;
        new_records();
        clear_obs();
        done_before = done_cnt;
        pulse_start();
        fork
            drive_src(stall, src_to);
            drain(rnd, snk_to);
            begin
                if (poke) begin
                    repeat (8) @(posedge ap_clk);
                    #1 start = 1'b1;
                    @(posedge ap_clk);
                    #1 start = 1'b0;
                end
            end
        join
        g = 0;
        while (done_cnt == done_before && g < 50) begin @(negedge ap_clk); g++; end
        repeat (2) @(negedge ap_clk);
        @(posedge ap_clk); #1;

        check("src_timeout", chk_t'(src_to), chk_t'(0));
        check("sink_timeout", chk_t'(snk_to), chk_t'(0));
        check("write_count", chk_t'(wr_cyc_q.size()), chk_t'(NUM));
        check("write_width", chk_t'(ew_wide), chk_t'(0));
        if (wr_cyc_q.size() == NUM) begin
            for (int k = 0; k < NUM; k++) begin
                check($sformatf("d_in[%0d]", k), chk_t'(wr_dat_q[k]), chk_t'(rec[k]));
                check($sformatf("wr_latency[%0d]", k), chk_t'(wr_cyc_q[k]), chk_t'(hs_cyc[k]));
            end
            for (int k = 1; k < NUM; k++) begin
                if (stall)
                    check($sformatf("wr_spacing_min[%0d]", k),
                          chk_t'(wr_cyc_q[k] - wr_cyc_q[k-1] >= GAP + 2), chk_t'(1));
                else
                    check($sformatf("wr_spacing[%0d]", k),
                          chk_t'(wr_cyc_q[k] - wr_cyc_q[k-1]), chk_t'(GAP + 2));
            end
            if (stall)
                check("stall_gap", chk_t'(wr_cyc_q[2] - wr_cyc_q[1] >= 20), chk_t'(1));
            if (rd_rise_q.size() > 0)
                check("settle_interval", chk_t'(rd_rise_q[0] - wr_cyc_q[NUM-1]), chk_t'(SETTLE + 1));
        end
        check("read_count", chk_t'(rd_rise_q.size()), chk_t'(NUM));
        check("result_count", chk_t'(got_q.size()), chk_t'(NUM));
        for (int k = 0; k < NUM && k < got_q.size(); k++)
            check($sformatf("res_data[%0d]", k), chk_t'(got_q[k]), chk_t'(32'hA0 + rd_base + k));
        check("req_while_ack", chk_t'(rc_viol), chk_t'(0));
        check("req_while_res_valid", chk_t'(rv_viol), chk_t'(0));
        check("done_pulses", chk_t'(done_cnt - done_before), chk_t'(1));
        exp_step++;
        rd_base += NUM;
        check("step", chk_t'(step), chk_t'(exp_step));
        check("busy_after_run", chk_t'(busy), chk_t'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int g;
        reset     = 1'b1;
        start     = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_busy", chk_t'(busy), chk_t'(0));
        check("rst_step", chk_t'(step), chk_t'(0));
        check("rst_d_in", chk_t'(d_in), chk_t'(0));
        check("rst_res_data", chk_t'(res_data), chk_t'(0));
        check("rst_elem_write", chk_t'(elem_write), chk_t'(0));
        check("rst_read_ctrl", chk_t'(read_ctrl), chk_t'(0));
        check("rst_res_valid", chk_t'(res_valid), chk_t'(0));
        check("rst_done", chk_t'(done), chk_t'(0));
        check("rst_src_ready", chk_t'(src_ready), chk_t'(0));
        reset = 1'b0;

        // Load with a 20-cycle source stall before record 2.
        run_once(1'b1, 1'b0, 1'b0);
        // Back-to-back run, sink toggling randomly, start poked mid-run.
        run_once(1'b0, 1'b1, 1'b1);

`ifdef MD_HOST_LINK_READ_TIMEOUT_EN
        begin
            bit src_to;
            int done_before, diff;
            stuck = 1'b1;
            new_records();
            clear_obs();
            done_before = done_cnt;
            pulse_start();
            drive_src(1'b0, src_to);
            g = 0;
            while (to_cyc_q.size() == 0 && g < SETTLE + 200) begin @(negedge ap_clk); g++; end
            repeat (3) @(negedge ap_clk);
            @(posedge ap_clk); #1;
            diff = (to_cyc_q.size() > 0 && rd_rise_q.size() > 0) ? to_cyc_q[0] - rd_rise_q[0] : -1;
            check("to_src_timeout", chk_t'(src_to), chk_t'(0));
            check("to_pulses", chk_t'(to_cyc_q.size()), chk_t'(1));
            check("to_delay", chk_t'(diff), chk_t'(RDTO));
            check("to_busy", chk_t'(busy), chk_t'(0));
            check("to_read_ctrl", chk_t'(read_ctrl), chk_t'(0));
            check("to_step", chk_t'(step), chk_t'(exp_step));
            check("to_no_done", chk_t'(done_cnt - done_before), chk_t'(0));
            stuck = 1'b0;
        end
`endif

        // Wrapper acknowledges ahead of the request.
        eager = 1'b1;
        run_once(1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of LD_GAP.
        new_records();
        pulse_start();
        src_valid = 1'b1;
        src_data  = rec[0];
        g = 0;
        do begin @(negedge ap_clk); g++; end while (!elem_write && g < 50);
        check("mid_write_seen", chk_t'(elem_write), chk_t'(1));
        @(posedge ap_clk); #1;
        src_valid = 1'b0;
        check("mid_busy_before", chk_t'(busy), chk_t'(1));
        #2 reset = 1'b1;
        #1;
        check("mid_rst_elem_write", chk_t'(elem_write), chk_t'(0));
        check("mid_rst_busy", chk_t'(busy), chk_t'(0));
        check("mid_rst_step", chk_t'(step), chk_t'(0));
        check("mid_rst_d_in", chk_t'(d_in), chk_t'(0));
        check("mid_rst_src_ready", chk_t'(src_ready), chk_t'(0));
        repeat (2) @(posedge ap_clk);
        #1 reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_host_link.md
Name: md_host_link

Overview:
- Host-side driver for MD_Wrapper's particle port.
- Load: streams NUM_PARTICLES records from a host valid/ready source into the wrapper's elem_write/d_in write port.
- Settle: waits a programmed settle interval.
- Unload: drains NUM_PARTICLES results through the read_ctrl/elem_read/d_out port onto a host valid/ready result stream, then advances step.
- Replaces the hand-timed stimulus currently used to run a timestep; sits between the host DMA/BRAM path and MD_Wrapper.

Parameters:
- NUM_PARTICLES, 300, particles transferred per direction per run
- IDX_W, 9, particle counter width (must satisfy 2^IDX_W > NUM_PARTICLES)
- DIN_W, 210, particle record width into wrapper (d_in)
- DOUT_W, 192, result record width out of wrapper (d_out)
- GAP_CYCLES, 16, idle cycles between consecutive elem_write pulses (minimum 1)
- SETTLE_CYCLES, 10000, cycles waited after last write before first read (minimum 1)

Ports:
- ap_clk  in  1  sole clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when IDLE, ignored otherwise
- src_valid  in  1  host particle record valid
- src_data  in  DIN_W  host particle record
- src_ready  out  1  host particle record accepted this cycle
- elem_write  out  1  write strobe to MD_Wrapper
- d_in  out  DIN_W  particle record to MD_Wrapper
- read_ctrl  out  1  read request to MD_Wrapper
- elem_read  in  1  read acknowledge from MD_Wrapper
- d_out  in  DOUT_W  result record from MD_Wrapper
- res_valid  out  1  result record valid to host
- res_data  out  DOUT_W  result record to host
- res_ready  in  1  host accepts result
- step  out  32  timestep number to MD_Wrapper
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0 (including d_in, res_data, step).
- States: IDLE, LD_WAIT, LD_WR, LD_GAP, SETTLE, RD_REQ, RD_REL, OUT, FIN.
- IDLE: start -> LD_WAIT, idx=0.
- LD_WAIT: src_ready=1 (combinational from state). On src_valid, register src_data into d_in -> LD_WR.
- LD_WR: elem_write=1 for exactly one cycle; d_in stable.
  - idx+1==NUM_PARTICLES -> SETTLE, counter=SETTLE_CYCLES-1.
  - Otherwise -> LD_GAP, counter=GAP_CYCLES-1, idx++.
- LD_GAP: elem_write=0; d_in held; counter reaching 0 -> LD_WAIT.
- SETTLE: count down; at 0 -> RD_REQ, idx=0.
- RD_REQ: read_ctrl=1 held until elem_read sampled 1. That cycle: capture d_out into res_data; read_ctrl drops next cycle -> RD_REL.
- RD_REL: read_ctrl=0; wait for elem_read=0 (4-phase handshake) -> OUT.
- OUT: res_valid=1, res_data stable, until res_ready.
  - Last particle -> FIN.
  - Otherwise -> RD_REQ, idx++.
- FIN: step<=step+1 (wraps 2^32-1 -> 0); done=1 for one cycle -> IDLE.
- Load latency: src handshake to elem_write is exactly 1 cycle. Back-to-back elem_write spacing is >= GAP_CYCLES+2.
- Boundary cases:
  - src_valid low in LD_WAIT: stalls indefinitely.
  - res_ready low in OUT: stalls; no new read is issued.
  - elem_read already 1 on entering RD_REQ: captured the same cycle.
  - start while busy: ignored.
  - reset mid-run: aborts immediately to IDLE, outputs 0, step cleared.

Optional Feature:
- Macro MD_HOST_LINK_READ_TIMEOUT_EN.
- Defined:
  - Adds parameter RD_TIMEOUT (default 4096) and output port rd_timeout (1 bit, reset 0).
  - If RD_REQ or RD_REL persists RD_TIMEOUT cycles: read_ctrl=0, rd_timeout pulses 1 cycle, state -> IDLE; step unchanged; done not asserted.
- Undefined: port and parameter absent; handshake waits forever.

Decomposition:
- Package md_link_pkg: state enum, DIN_W/DOUT_W defaults, step width 32.
- Single sub-module md_down_counter (load/decrement/zero flag), shared by GAP, SETTLE and timeout counting.
- FSM and datapath live in md_host_link.

Test Plan:
- Reset: assert reset mid-LD_GAP -> elem_write=0, busy=0, step=0 within the same cycle (asynchronous).
- Load (NUM_PARTICLES=4, GAP_CYCLES=3, src always valid): exactly 4 elem_write pulses, each 1 cycle, spaced 5 cycles; d_in equals records 0..3 in order.
- Load stall: src_valid low 20 cycles before record 2 -> no elem_write during stall; order preserved.
- Unload (model acks after 3 cycles, d_out=0xA0+i): res_data = 0xA0..0xA3; read_ctrl never re-asserts while elem_read=1.
- Run end (res_ready toggled 50%, two back-to-back runs): no result lost; done pulses twice; step 0 -> 1 -> 2.
- Timeout (MD_HOST_LINK_READ_TIMEOUT_EN, RD_TIMEOUT=8, elem_read stuck 0): rd_timeout pulses after 8 cycles in RD_REQ; state IDLE; step unchanged.
